memory_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 5 +
 rtl/memory_arbiter_if.sv | 28 ++
 rtl/memory_arbiter.sv | 96 +++++++++
 tb/tb_memory_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the unified-RAM arbiter
package arb_pkg;
  typedef enum logic [2:0] {IDLE, IACC, DACC, IRESP, DRESP} arb_state_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - signal bundle between fetch, data port, arbiter and RAM
interface memory_arbiter_if;
  import arb_pkg::*;
  logic  iREN;
  word_t iaddr;
  word_t iload;
  logic  ihit;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  word_t dload;
  logic  dhit;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ram_ready;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore
  );
  modport ifetch (output iREN, iaddr, input iload, ihit);
  modport dmem (output dREN, dWEN, daddr, dstore, input dload, dhit);
  modport ram (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ram_ready);
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - data-first arbiter for the single-ported unified RAM
// with a starvation counter that forces an instruction grant.
module memory_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        busy
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t state, next_state;
  word_t      addr_q, store_q;
  logic       wr;
  logic [3:0] scnt;
  logic       dreq, force_i, grant_d, grant_i;

  always_comb begin
    dreq    = dREN | dWEN;
    force_i = iREN && (scnt == SMAX);
    grant_d = (state == IDLE) && dreq && !force_i;
    grant_i = (state == IDLE) && !grant_d && iREN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d)      next_state = DACC;
        else if (grant_i) next_state = IACC;
      end
      IACC:    if (ram_ready) next_state = IRESP;
      DACC:    if (ram_ready) next_state = DRESP;
      IRESP:   next_state = IDLE;
      DRESP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and hits are pure state decodes, so ram_ready never reaches an output.
  assign ramREN   = (state == IACC) || ((state == DACC) && !wr);
  assign ramWEN   = (state == DACC) && wr;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign ihit     = (state == IRESP);
  assign dhit     = (state == DRESP);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= '0;
      store_q <= '0;
      wr      <= 1'b0;
      scnt    <= '0;
      iload   <= '0;
      dload   <= '0;
    end else begin
      if (grant_d) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wr      <= dWEN;
        if (iREN && scnt != SMAX) scnt <= scnt + 4'd1;
      end else if (grant_i) begin
        addr_q <= iaddr;
        scnt   <= '0;
      end
      if (state == IACC && ram_ready)        iload <= ramload;
      if (state == DACC && ram_ready && !wr) dload <= ramload;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed scoreboard bench for memory_arbiter
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        ram_ready = 1'b0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [logic [31:0]];
  int          ram_delay = 0;
  bit          rand_delay = 0;
  int          acc_cnt = 0;

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic push(input bit is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  // RAM model: ready after ram_delay extra strobe cycles, writes land on ready
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      if (acc_cnt == 0 && rand_delay) ram_delay = $urandom_range(0, 2);
      if (acc_cnt == ram_delay) begin
        ram_ready = 1'b1;
        ramload   = mem_rd(ramaddr);
        if (ramWEN) mem[ramaddr] = ramstore;
      end else begin
        ram_ready = 1'b0;
      end
      acc_cnt++;
    end else begin
      acc_cnt   = 0;
      ram_ready = 1'b0;
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    chk("hit_exclusive", 32'(ihit & dhit), 32'd0);
    chk("strobe_outside_acc", 32'((ramREN | ramWEN) & ~busy), 32'd0);
    if (ihit || dhit) begin
      if (sb.size() == 0) begin
        chk("unexpected_hit", 32'(dhit), 32'(ihit));
        chk("unexpected_hit_any", 32'd1, 32'd0 + 32'(sb.size()));
      end else begin
        e = sb.pop_front();
        chk("hit_port", 32'(dhit), 32'(e.is_d));
        chk("hit_data", dhit ? dload : iload, e.data);
        if (ihit) chk("scnt_after_i", 32'(dut.scnt), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem[32'h40] = 32'h8C01_0004;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_hits", 32'({ihit, dhit}), 0);
    chk("rst_scnt", 32'(dut.scnt), 0);

    // instruction read, k=0
    iREN = 1'b1; iaddr = 32'h40; ram_delay = 0;
    push(1'b0, 32'h8C01_0004);
    @(negedge CLK);
    chk("i_acc_ihit", 32'(ihit), 0);
    chk("i_acc_ramREN", 32'(ramREN), 1);
    chk("i_acc_ramWEN", 32'(ramWEN), 0);
    chk("i_acc_ramaddr", ramaddr, 32'h40);
    @(negedge CLK);
    chk("i_hit_t2", 32'(ihit), 1);
    chk("i_iload", iload, 32'h8C01_0004);
    chk("i_no_dhit", 32'(dhit), 0);
    iREN = 1'b0;
    @(negedge CLK);
    chk("i_idle", 32'(busy), 0);

    // data write, ram_ready 3 cycles late
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ram_delay = 3;
    push(1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("w_ramWEN", 32'(ramWEN), 1);
      chk("w_ramREN", 32'(ramREN), 0);
      chk("w_ramaddr", ramaddr, 32'h100);
      chk("w_ramstore", ramstore, 32'hDEAD_BEEF);
      chk("w_dhit_early", 32'(dhit), 0);
    end
    @(negedge CLK);
    chk("w_dhit_t5", 32'(dhit), 1);
    chk("w_dload_kept", dload, 32'h0);
    dWEN = 1'b0;
    @(negedge CLK);

    // contention: grant order D,D,D,D,I repeated
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100; rand_delay = 1;
    for (int g = 0; g < 10; g++)
      push((g % 5) != 4, (g % 5) != 4 ? 32'hDEAD_BEEF : 32'h8C01_0004);
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge CLK);
      if (ihit || dhit) n++;
    end
    chk("cont_hits", 32'(n), 32'd10);
    iREN = 1'b0; dREN = 1'b0; rand_delay = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("cont_idle", 32'(busy), 0);

    // write wins over a simultaneous read
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678; ram_delay = 1;
    push(1'b1, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("wp_ramWEN", 32'(ramWEN), 1);
    chk("wp_ramREN", 32'(ramREN), 0);
    for (int c = 0; c < 20 && !dhit; c++) @(negedge CLK);
    chk("wp_dhit", 32'(dhit), 1);
    dREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);

    // reset in the middle of a data access
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h300; ram_delay = 20;
    @(negedge CLK);
    chk("rm_ramREN", 32'(ramREN), 1);
    chk("rm_scnt", 32'(dut.scnt), 1);
    iREN = 1'b0; dREN = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("rm_strobes_drop", 32'({ramREN, ramWEN}), 0);
    chk("rm_busy", 32'(busy), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rm_idle", 32'(busy), 0);
    chk("rm_scnt_clr", 32'(dut.scnt), 0);
    chk("rm_dload_clr", dload, 0);
    repeat (3) @(negedge CLK);

    // request dropped while in IACC
    iREN = 1'b1; iaddr = 32'h80; ram_delay = 2;
    push(1'b0, 32'hA5A5_0080);
    @(negedge CLK);
    chk("dr_in_iacc", 32'(ramREN), 1);
    iREN = 1'b0;
    for (int c = 0; c < 20 && !ihit; c++) @(negedge CLK);
    chk("dr_ihit", 32'(ihit), 1);
    @(negedge CLK);
    chk("dr_ihit_once", 32'(ihit), 0);
    chk("dr_idle", 32'(busy), 0);
    repeat (3) @(negedge CLK);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
